rgb_led_scheduler: RTL

RGB_LED_SCHEDULER -- requirements
Module: rgb_led_scheduler

---
 rtl/rgb_led_scheduler.sv | 95 +++++++++
 1 files changed

// File: rtl/rgb_led_scheduler.sv
// rgb_led_scheduler: round-robin arbiter that lends one active-low RGB LED to a requester
// for a fixed display window, followed by an optional dark gap.
module rgb_led_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 2000000,
  parameter int GAP_CYCLES  = 12000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   color,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   RGB_R,
  output logic                   RGB_G,
  output logic                   RGB_B
);
  localparam int MAXC = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int PW   = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d, win_q, win_d, pick, next_ptr;
  logic [2:0]           color_q, color_d, pick_color, rgb_q, rgb_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic [2*NUM_REQ-1:0] req_rot;
  logic [6*NUM_REQ-1:0] color_rot;
  int                   pick_sum;
  // Rotate so bit k is requester (rr_ptr+k) mod NUM_REQ; lowest set k wins.
  always_comb begin
    req_rot    = {req, req} >> rr_ptr_q;
    color_rot  = {color, color} >> (3 * rr_ptr_q);
    pick_sum   = 0;
    pick_color = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_rot[k]) begin
        pick_sum   = int'(rr_ptr_q) + k;
        pick_color = color_rot[3*k +: 3];
      end
    pick     = PW'(pick_sum >= NUM_REQ ? pick_sum - NUM_REQ : pick_sum);
    next_ptr = win_q == PW'(NUM_REQ - 1) ? '0 : win_q + 1'b1;
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    color_d  = color_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d = SHOW;
        cnt_d   = CW'(HOLD_CYCLES - 1);
        win_d   = pick;
        color_d = pick_color;
      end
      SHOW: if (cnt_q == '0) begin
        rr_ptr_d = next_ptr;
        state_d  = GAP_CYCLES > 0 ? GAP : IDLE;
        cnt_d    = GAP_CYCLES > 0 ? CW'(GAP_CYCLES - 1) : '0;
      end else cnt_d = cnt_q - 1'b1;
      GAP: if (cnt_q == '0) state_d = IDLE;
           else cnt_d = cnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
    grant_d = state_d == SHOW ? NUM_REQ'(1) << win_d : '0;
    busy_d  = state_d != IDLE;
    rgb_d   = state_d == SHOW ? ~color_d : 3'b111;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      win_q    <= '0;
      color_q  <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      rgb_q    <= 3'b111;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      color_q  <= color_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      rgb_q    <= rgb_d;
    end
  end
  assign grant                = grant_q;
  assign busy                 = busy_q;
  assign {RGB_R, RGB_G, RGB_B} = rgb_q;
endmodule
